// File: rtl/wb_write_queue.sv
// wb_write_queue: arbitrated in-order write-back FIFO feeding a single register-file write port
module wb_write_queue #(
  parameter int WORD_LEN = 32,
  parameter int REG_FILE_ADDR_LEN = 4,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic exe_valid,
  output logic exe_ready,
  input  logic [REG_FILE_ADDR_LEN-1:0] exe_dest,
  input  logic [WORD_LEN-1:0] exe_val,
  input  logic mem_valid,
  output logic mem_ready,
  input  logic [REG_FILE_ADDR_LEN-1:0] mem_dest,
  input  logic [WORD_LEN-1:0] mem_val,
  input  logic hold,
  output logic writeEn,
  output logic [REG_FILE_ADDR_LEN-1:0] dest,
  output logic [WORD_LEN-1:0] writeVal,
  output logic [(1<<REG_FILE_ADDR_LEN)-1:0] pending,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [REG_FILE_ADDR_LEN-1:0] fd_q [DEPTH];
  logic [WORD_LEN-1:0] fv_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q, count_d;
  logic we_q;
  logic [REG_FILE_ADDR_LEN-1:0] dest_q, in_dest;
  logic [WORD_LEN-1:0] val_q, in_val;
  logic pop, space, push;
  // Arbitration (mem wins), space check and occupancy update; dest-0 writes are accepted but dropped
  always_comb begin
    pop = count_q != '0 && !hold;
    space = count_q < CW'(DEPTH) || pop;
    mem_ready = mem_valid && space && !rst;
    exe_ready = exe_valid && !mem_valid && space && !rst;
    in_dest = mem_valid ? mem_dest : exe_dest;
    in_val = mem_valid ? mem_val : exe_val;
    push = (mem_ready || exe_ready) && in_dest != '0;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  // Control state and registered write port; a push into the slot being popped sets vld after the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      we_q <= 1'b0;
      dest_q <= '0;
      val_q <= '0;
    end else begin
      count_q <= count_d;
      we_q <= pop;
      if (pop) begin
        dest_q <= fd_q[rd_q];
        val_q <= fv_q[rd_q];
        rd_q <= rd_q + 1'b1;
        vld_q[rd_q] <= 1'b0;
      end
      if (push) begin
        wr_q <= wr_q + 1'b1;
        vld_q[wr_q] <= 1'b1;
      end
    end
  end
  // Entry payload storage; contents are only meaningful where vld_q is set
  always_ff @(posedge clk) begin
    if (push) begin
      fd_q[wr_q] <= in_dest;
      fv_q[wr_q] <= in_val;
    end
  end
  // Registers with a queued write or a write currently on the port
  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) if (vld_q[i]) pending[fd_q[i]] = 1'b1;
    if (we_q) pending[dest_q] = 1'b1;
  end
  assign writeEn = we_q;
  assign dest = dest_q;
  assign writeVal = val_q;
  assign count = count_q;
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: randomized scoreboard bench for wb_write_queue
module tb_wb_write_queue;
  typedef struct packed {logic [3:0] d; logic [31:0] v;} wr_t;
  logic clk = 1'b0, rst = 1'b1, hold = 1'b0;
  logic exe_valid = 1'b0, mem_valid = 1'b0, exe_ready, mem_ready;
  logic [3:0] exe_dest = '0, mem_dest = '0, dest;
  logic [31:0] exe_val = '0, mem_val = '0, writeVal;
  logic writeEn;
  logic [15:0] pending;
  logic [2:0] count;
  int vectors = 0, miscompares = 0;
  wr_t exp_q[$];
  logic exp_we = 1'b0, exp_rst = 1'b1;
  logic [3:0] last_d = '0;
  logic [31:0] last_v = '0;

  wb_write_queue #(.WORD_LEN(32), .REG_FILE_ADDR_LEN(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_dest(exe_dest), .exe_val(exe_val),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_val(mem_val),
    .hold(hold), .writeEn(writeEn), .dest(dest), .writeVal(writeVal),
    .pending(pending), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // One cycle: drive at posedge+1, check readies and update the model at posedge-1
  task automatic cyc(input logic r, input logic h,
                     input logic mv, input logic [3:0] md, input logic [31:0] mvl,
                     input logic ev, input logic [3:0] ed, input logic [31:0] evl,
                     output logic macc, output logic eacc);
    logic sp;
    rst = r; hold = h;
    mem_valid = mv; mem_dest = md; mem_val = mvl;
    exe_valid = ev; exe_dest = ed; exe_val = evl;
    #8;
    sp = exp_q.size() < 4 || (exp_q.size() > 0 && !h);
    macc = mv && sp && !r;
    eacc = ev && !mv && sp && !r;
    chk("mem_ready", 64'(mem_ready), 64'(macc));
    chk("exe_ready", 64'(exe_ready), 64'(eacc));
    exp_rst = r;
    exp_we = !r && exp_q.size() > 0 && !h;
    if (r) exp_q.delete();
    else if (macc && md != 0) exp_q.push_back({md, mvl});
    else if (eacc && ed != 0) exp_q.push_back({ed, evl});
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the write port against the scoreboard after every edge
  always @(negedge clk) begin
    logic [15:0] p;
    wr_t w;
    chk("writeEn", 64'(writeEn), 64'(exp_we));
    if (exp_rst) begin
      last_d = '0;
      last_v = '0;
    end else if (writeEn) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: dest %0h val %0h with empty scoreboard", dest, writeVal);
      end else begin
        w = exp_q.pop_front();
        last_d = w.d;
        last_v = w.v;
      end
    end
    chk("dest", 64'(dest), 64'(last_d));
    chk("writeVal", 64'(writeVal), 64'(last_v));
    chk("count", 64'(count), 64'(exp_q.size()));
    p = '0;
    foreach (exp_q[i]) p[exp_q[i].d] = 1'b1;
    if (exp_we && !exp_rst) p[last_d] = 1'b1;
    chk("pending", 64'(pending), 64'(p));
  end

  initial begin
    logic ma, ea, mo, eo, h, r;
    logic [3:0] md, ed;
    logic [31:0] mvl, evl;
    mo = 0; eo = 0; md = 0; ed = 0; mvl = 0; evl = 0;
    @(posedge clk);
    #1;
    repeat (2) cyc(1, 0, 1, 5, 32'hA, 1, 6, 32'hB, ma, ea);
    cyc(0, 0, 0, 0, 0, 1, 3, 32'h12345678, ma, ea);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, ma, ea);
    cyc(0, 0, 1, 5, 32'hA, 1, 6, 32'hB, ma, ea);
    cyc(0, 0, 0, 0, 0, 1, 6, 32'hB, ma, ea);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, ma, ea);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 0, 0, 0, 1, 4'(i), 32'(i), ma, ea);
    cyc(0, 1, 0, 0, 0, 1, 7, 32'h77, ma, ea);
    cyc(0, 0, 1, 7, 32'h77, 0, 0, 0, ma, ea);
    repeat (6) cyc(0, 0, 0, 0, 0, 0, 0, 0, ma, ea);
    cyc(0, 0, 0, 0, 0, 1, 0, 32'hFFFF, ma, ea);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 0, ma, ea);
    for (int i = 1; i <= 4; i++) cyc(0, 1, 1, 4'(i + 8), 32'(i * 3), 0, 0, 0, ma, ea);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, ma, ea);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, ma, ea);
    repeat (6) cyc(0, 0, 0, 0, 0, 0, 0, 0, ma, ea);
    for (int n = 0; n < 600; n++) begin
      if (!mo && $urandom_range(1, 0) == 1) begin
        mo = 1; md = 4'($urandom_range(15, 0)); mvl = $urandom;
      end
      if (!eo && $urandom_range(1, 0) == 1) begin
        eo = 1; ed = 4'($urandom_range(15, 0)); evl = $urandom;
      end
      h = $urandom_range(3, 0) == 0;
      r = $urandom_range(63, 0) == 0;
      cyc(r, h, mo, md, mvl, eo, ed, evl, ma, ea);
      if (ma) mo = 0;
      if (ea) eo = 0;
    end
    repeat (6) cyc(0, 0, 0, 0, 0, 0, 0, 0, ma, ea);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
